// File: rtl/con_ff_unit.sv
// con_ff_unit: registered condition evaluator with a one-cycle evaluation stage,
// a hold/acknowledge handshake and optional saturating statistics counters.
//
// Optional feature macro: CON_FF_UNIT_STATS_EN
//   defined   -> eval / taken counters are built (saturating, cleared by in_stat_clr)
//   undefined -> count outputs are tied to 0 and in_stat_clr is ignored
//
// Ports:
//   clk             clock, all state changes on rising edge
//   clr             asynchronous active-high reset
//   in_con_in       evaluate strobe; captures in_condition and in_bus
//   in_condition    3-bit condition code
//   in_bus          WIDTH-bit operand (sign is bit WIDTH-1)
//   in_ack          consumer has taken the result (honoured only while holding)
//   in_stat_clr     synchronous clear of both statistics counters
//   out_branch      registered branch decision
//   out_valid       out_branch holds a fresh, unacknowledged result
//   out_busy        an evaluation is in flight
//   out_eval_count  completed evaluations (COUNT_W bits)
//   out_taken_count completed evaluations with a true result (COUNT_W bits)
module con_ff_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_con_in,
  input  logic [2:0]         in_condition,
  input  logic [WIDTH-1:0]   in_bus,
  input  logic               in_ack,
  input  logic               in_stat_clr,
  output logic               out_branch,
  output logic               out_valid,
  output logic               out_busy,
  output logic [COUNT_W-1:0] out_eval_count,
  output logic [COUNT_W-1:0] out_taken_count
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StEval = 2'b01,
    StHold = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cap_bus_q, cap_bus_d;
  logic [2:0]       cap_cond_q, cap_cond_d;
  logic             branch_q, branch_d;
  logic             valid_q, valid_d;
  logic             eval_done;
  logic             decision;
  logic             op_zero;
  logic             op_neg;

  // Decision depends only on the captured operand/code, never on live inputs.
  always_comb begin
    op_zero  = (cap_bus_q == '0);
    op_neg   = cap_bus_q[WIDTH-1];
    decision = 1'b0;
    unique case (cap_cond_q)
      3'b000: decision = op_zero;
      3'b001: decision = !op_zero;
      3'b010: decision = !op_neg;
      3'b011: decision = op_neg;
      3'b100: decision = !op_neg && !op_zero;
      3'b101: decision = op_neg || op_zero;
      3'b110: decision = 1'b1;
      3'b111: decision = 1'b0;
      default: decision = 1'b0;
    endcase
  end

  // A strobe wins in every state: it restarts evaluation and drops any
  // pending or in-flight result.
  always_comb begin
    state_d    = state_q;
    cap_bus_d  = cap_bus_q;
    cap_cond_d = cap_cond_q;
    branch_d   = branch_q;
    valid_d    = valid_q;
    eval_done  = 1'b0;
    if (in_con_in) begin
      cap_bus_d  = in_bus;
      cap_cond_d = in_condition;
      valid_d    = 1'b0;
      state_d    = StEval;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StEval: begin
          branch_d  = decision;
          valid_d   = 1'b1;
          state_d   = StHold;
          eval_done = 1'b1;
        end
        StHold: begin
          if (in_ack) begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      cap_bus_q  <= '0;
      cap_cond_q <= '0;
      branch_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_bus_q  <= cap_bus_d;
      cap_cond_q <= cap_cond_d;
      branch_q   <= branch_d;
      valid_q    <= valid_d;
    end
  end

  assign out_branch = branch_q;
  assign out_valid  = valid_q;
  assign out_busy   = (state_q == StEval);

`ifdef CON_FF_UNIT_STATS_EN
  logic [COUNT_W-1:0] eval_cnt_q, eval_cnt_d;
  logic [COUNT_W-1:0] taken_cnt_q, taken_cnt_d;

  // Clear beats a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    eval_cnt_d  = eval_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (in_stat_clr) begin
      eval_cnt_d  = '0;
      taken_cnt_d = '0;
    end else if (eval_done) begin
      if (eval_cnt_q != '1) begin
        eval_cnt_d = eval_cnt_q + 1'b1;
      end
      if (decision && (taken_cnt_q != '1)) begin
        taken_cnt_d = taken_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      eval_cnt_q  <= '0;
      taken_cnt_q <= '0;
    end else begin
      eval_cnt_q  <= eval_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign out_eval_count  = eval_cnt_q;
  assign out_taken_count = taken_cnt_q;
`else
  logic unused_stats;
  assign unused_stats    = in_stat_clr | eval_done;
  assign out_eval_count  = '0;
  assign out_taken_count = '0;
`endif

endmodule

// File: tb/tb_con_ff_unit.sv
// Bench for con_ff_unit: a WIDTH=32 and a WIDTH=8 instance share stimulus; a
// transaction-level model predicts every output each cycle, plus directed
// literal checks for the documented scenarios.
module tb_con_ff_unit;

`ifdef CON_FF_UNIT_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        in_con_in = 1'b0;
  logic [2:0]  in_condition = 3'd0;
  logic [31:0] in_bus = 32'd0;
  logic        in_ack = 1'b0;
  logic        in_stat_clr = 1'b0;

  logic       br32, val32, busy32, br8, val8, busy8;
  logic [3:0] ev32, tk32, ev8, tk8;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  con_ff_unit #(.WIDTH(32), .COUNT_W(4)) dut32 (
    .clk(clk), .clr(clr), .in_con_in(in_con_in), .in_condition(in_condition),
    .in_bus(in_bus), .in_ack(in_ack), .in_stat_clr(in_stat_clr),
    .out_branch(br32), .out_valid(val32), .out_busy(busy32),
    .out_eval_count(ev32), .out_taken_count(tk32)
  );

  con_ff_unit #(.WIDTH(8), .COUNT_W(4)) dut8 (
    .clk(clk), .clr(clr), .in_con_in(in_con_in), .in_condition(in_condition),
    .in_bus(in_bus[7:0]), .in_ack(in_ack), .in_stat_clr(in_stat_clr),
    .out_branch(br8), .out_valid(val8), .out_busy(busy8),
    .out_eval_count(ev8), .out_taken_count(tk8)
  );

  // Condition semantics on the operand's signed value.
  function automatic bit decide(input logic [2:0] code, input longint v);
    case (code)
      3'd0:    return v == 0;
      3'd1:    return v != 0;
      3'd2:    return v >= 0;
      3'd3:    return v < 0;
      3'd4:    return v > 0;
      3'd5:    return v <= 0;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkc(input string name, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a strobe starts a pending evaluation; a pending evaluation with no
  // new strobe becomes a visible result one edge later; ack retires a result.
  bit          m_busy = 0, m_valid = 0, m_br32 = 0, m_br8 = 0, m_done = 0;
  logic [2:0]  m_cond = 3'd0;
  logic [31:0] m_bus = 32'd0;
  logic [3:0]  m_ev = 4'd0, m_tk32 = 4'd0, m_tk8 = 4'd0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_busy = 0; m_valid = 0; m_br32 = 0; m_br8 = 0;
      m_cond = 3'd0; m_bus = 32'd0;
      m_ev = 4'd0; m_tk32 = 4'd0; m_tk8 = 4'd0;
    end else begin
      m_done = 0;
      if (in_con_in) begin
        m_busy = 1; m_valid = 0; m_cond = in_condition; m_bus = in_bus;
      end else if (m_busy) begin
        m_busy = 0; m_valid = 1; m_done = 1;
        m_br32 = decide(m_cond, longint'($signed(m_bus)));
        m_br8  = decide(m_cond, longint'($signed(m_bus[7:0])));
      end else if (m_valid && in_ack) begin
        m_valid = 0;
      end
      if (StatsEn) begin
        if (in_stat_clr) begin
          m_ev = 4'd0; m_tk32 = 4'd0; m_tk8 = 4'd0;
        end else if (m_done) begin
          if (m_ev != 4'd15) m_ev = m_ev + 4'd1;
          if (m_br32 && m_tk32 != 4'd15) m_tk32 = m_tk32 + 4'd1;
          if (m_br8 && m_tk8 != 4'd15) m_tk8 = m_tk8 + 4'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check1("valid32", val32, m_valid);
      check1("busy32", busy32, m_busy);
      check1("branch32", br32, m_br32);
      checkc("evcnt32", ev32, m_ev);
      checkc("tkcnt32", tk32, m_tk32);
      check1("valid8", val8, m_valid);
      check1("busy8", busy8, m_busy);
      check1("branch8", br8, m_br8);
      checkc("evcnt8", ev8, m_ev);
      checkc("tkcnt8", tk8, m_tk8);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ops [5];
  logic [31:0] specials [7];

  initial begin
    ops = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    specials = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h80, 32'h7F};

    // Reset state
    cycle(); cycle();
    check1("rst_valid", val32, 1'b0);
    check1("rst_branch", br32, 1'b0);
    check1("rst_busy", busy32, 1'b0);
    checkc("rst_evcnt", ev32, 4'd0);
    clr = 1'b0;
    chk_en = 1'b1;
    cycle();

    // clr mid-evaluation
    in_con_in = 1'b1; in_condition = 3'b000; in_bus = 32'h0;
    cycle();
    check1("abort_busy_before", busy32, 1'b1);
    in_con_in = 1'b0; clr = 1'b1;
    #1;
    check1("abort_busy", busy32, 1'b0);
    check1("abort_valid", val32, 1'b0);
    cycle();
    clr = 1'b0;
    cycle();
    check1("abort_valid_after", val32, 1'b0);
    checkc("abort_evcnt", ev32, 4'd0);

    // Sweep all codes over boundary operands
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 5; k++) begin
        in_con_in = 1'b1; in_condition = 3'(c); in_bus = ops[k];
        cycle();
        check1("sweep_busy", busy32, 1'b1);
        check1("sweep_notyet", val32, 1'b0);
        in_con_in = 1'b0; in_bus = $urandom;
        cycle();
        check1("sweep_valid", val32, 1'b1);
        check1("sweep_branch", br32, decide(3'(c), longint'($signed(ops[k]))));
        if (c == 4 && k == 4) check1("ex_gt0_neg1", br32, 1'b0);
        if (c == 5 && k == 0) check1("ex_le0_zero", br32, 1'b1);
        in_ack = 1'b1;
        cycle();
        in_ack = 1'b0;
      end
    end

    // Hold and ack
    in_con_in = 1'b1; in_condition = 3'b001; in_bus = 32'd5;
    cycle();
    in_con_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check1("hold_valid", val32, 1'b1);
      check1("hold_branch", br32, 1'b1);
    end
    in_ack = 1'b1;
    cycle();
    in_ack = 1'b0;
    check1("ack_valid", val32, 1'b0);
    check1("ack_branch", br32, 1'b1);

    // Strobe during evaluation: first result discarded
    in_con_in = 1'b1; in_condition = 3'b110; in_bus = 32'd0;
    cycle();
    in_condition = 3'b111;
    cycle();
    check1("restart_novalid", val32, 1'b0);
    in_con_in = 1'b0;
    cycle();
    check1("restart_valid", val32, 1'b1);
    check1("restart_branch", br32, 1'b0);

    // Strobe together with ack while holding
    in_con_in = 1'b1; in_ack = 1'b1; in_condition = 3'b110;
    cycle();
    check1("collide_valid", val32, 1'b0);
    check1("collide_busy", busy32, 1'b1);
    in_con_in = 1'b0; in_ack = 1'b0;
    cycle();
    check1("collide_new_valid", val32, 1'b1);
    check1("collide_new_branch", br32, 1'b1);

    // Statistics: 20 evaluations, 12 true, 4-bit counters
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_con_in = 1'b1; in_condition = (i < 12) ? 3'b110 : 3'b111;
      cycle();
      in_con_in = 1'b0;
      cycle();
    end
    checkc("stat_ev_sat", ev32, StatsEn ? 4'd15 : 4'd0);
    checkc("stat_taken", tk32, StatsEn ? 4'd12 : 4'd0);
    checkc("stat_ev_sat8", ev8, StatsEn ? 4'd15 : 4'd0);
    in_con_in = 1'b1; in_condition = 3'b110;
    cycle();
    in_con_in = 1'b0; in_stat_clr = 1'b1;
    cycle();
    in_stat_clr = 1'b0;
    check1("statclr_valid", val32, 1'b1);
    checkc("statclr_ev", ev32, 4'd0);
    checkc("statclr_tk", tk32, 4'd0);

    // Narrow operand sign handling
    in_con_in = 1'b1; in_condition = 3'b011; in_bus = 32'h80;
    cycle();
    in_con_in = 1'b0;
    cycle();
    check1("w8_neg", br8, 1'b1);
    check1("w32_pos", br32, 1'b0);
    in_con_in = 1'b1; in_condition = 3'b010; in_bus = 32'h7F;
    cycle();
    in_con_in = 1'b0;
    cycle();
    check1("w8_ge0", br8, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 99) < 2);
      in_con_in = ($urandom_range(0, 99) < 30);
      in_condition = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) in_bus = specials[$urandom_range(0, 6)];
      else in_bus = $urandom;
      in_ack = ($urandom_range(0, 99) < 40);
      in_stat_clr = ($urandom_range(0, 99) < 5);
      cycle();
    end
    clr = 1'b0; in_con_in = 1'b0; in_ack = 1'b0; in_stat_clr = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
